id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and EX operand-forwarding stage for the RV32I five-stage core. It sits directly upstream of the ALU: it captures decoded instructions, detects load-use hazards and inserts bubbles, and drives the ALU's `d1`, `d2` and `choice` inputs. Operands are forwarded from the MEM and WB stages. It also passes memory and writeback control to EX/MEM.

## Interface
Parameters:
- `BW`, 32, datapath width.
- `RW`, 5, register-index width.

Ports (reset is synchronous, active-high; single clock domain):
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  synchronous active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  BW  instruction PC.
- `id_rs1`, `id_rs2`, `id_rd`  in  RW each  register indices.
- `id_rs1_val`, `id_rs2_val`  in  BW each  register-file read data.
- `id_imm`  in  BW  sign-extended immediate.
- `id_alu_op`  in  4  ALU op code (para.sv encoding).
- `id_src1_pc`  in  1  `d1` selects PC instead of rs1.
- `id_src2_imm`  in  1  `d2` selects immediate instead of rs2.
- `id_reg_we`, `id_mem_re`, `id_mem_we`  in  1 each  writeback, load and store control.
- `flush`  in  1  kill the instruction currently in ID (branch redirect).
- `ex_hold`  in  1  downstream stall; freeze EX.
- `mem_reg_we`  in  1  MEM-stage writeback enable.
- `mem_rd`  in  RW  MEM-stage destination register.
- `mem_result`  in  BW  MEM-stage ALU result.
- `wb_reg_we`  in  1  WB-stage writeback enable.
- `wb_rd`  in  RW  WB-stage destination register.
- `wb_data`  in  BW  WB-stage writeback data.
- `id_stall`  out  1  hold IF/ID this cycle (combinational).
- `ex_valid`, `ex_reg_we`, `ex_mem_re`, `ex_mem_we`  out  1 each  registered control.
- `ex_rd`  out  RW  registered destination register.
- `ex_pc`  out  BW  registered PC.
- `ex_d1`, `ex_d2`  out  BW  ALU operands.
- `ex_choice`  out  4  ALU op code.
- `ex_store_data`  out  BW  forwarded rs2 value, used as store data.

## Operation
- The EX register updates on each rising edge. Priority, highest first:
  1. `rst`: every registered output is 0.
  2. `ex_hold`: all EX fields retain their values.
  3. `flush` or load-use bubble: EX becomes a bubble (all registered fields 0).
  4. Otherwise: capture the `id_*` fields, with `ex_valid` = `id_valid`.
- Load-use condition: `ex_valid & ex_mem_re & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
- `id_stall` = `ex_hold | load-use` (with `FWD_EN`). `flush` never asserts `id_stall`.
- Capture bypass: if `wb_reg_we & wb_rd!=0 & wb_rd==id_rsN`, capture `wb_data` instead of `id_rsN_val`. This covers a register file that reads before it writes.
- Forwarding of each stored rsN value (rs index 0 is never forwarded):
  - MEM match (`mem_reg_we`, `mem_rd==ex_rsN`) gives `mem_result`.
  - Otherwise a WB match gives `wb_data`.
  - Otherwise the captured value is used.
  - If MEM and WB both match, MEM wins.
- Operand selection:
  - `ex_d1` = `ex_src1_pc` ? `ex_pc` : fwd_rs1.
  - `ex_d2` = `ex_src2_imm` ? `ex_imm` : fwd_rs2.
  - `ex_store_data` = fwd_rs2.
  - `ex_choice` = registered op.
- A load sitting in MEM is not forwarded through `mem_result`. The one-cycle load-use stall guarantees such a load has reached WB before its consumer is in EX.

## Timing
- ID to EX latency is 1 cycle.
- `ex_d1`, `ex_d2` and `ex_store_data` are combinational from the EX register and the MEM/WB inputs. There is no additional latency.
- A load-use hazard costs exactly one bubble cycle. `id_stall` is high for that one cycle only.
- `flush` together with `ex_hold`: hold wins. The branch logic keeps `flush` asserted until hold releases.
- `rst` asserted mid-stall: the next cycle shows all outputs 0, and `id_stall` is low unless `ex_hold` is high.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding muxes present; behaviour is as above.
- `ID_EX_FWD_EN` undefined:
  - No forwarding; `ex_d1`/`ex_d2` use only the captured values.
  - `id_stall` also asserts for any rs match (nonzero) against an EX destination (`ex_valid & ex_reg_we`) or a MEM destination (`mem_reg_we`). This gives up to 2 stall cycles; each stall cycle inserts a bubble.
  - The WB capture bypass is retained.

## Structure
- Shared package `cpu_pkg` contains:
  - `ex_ctrl_t` struct: valid, reg_we, mem_re, mem_we, src1_pc, src2_imm, alu_op.
  - The `RW` width constant.
  - The ALU op code width.
- Sub-module `fwd_mux`: one per source operand (rs1, rs2). Inputs are index, captured value and the MEM/WB ports; output is the forwarded value.

## Test plan
- Reset: hold `rst` 2 cycles with `id_valid`=1 → all registered outputs 0 and `id_stall`=0; first capture appears the cycle after `rst` drops.
- ALU-ALU forward: `add x5` in MEM (`mem_result`=0x10) and a consumer with rs1=5 in EX → `ex_d1`=0x10. When WB also has rd=5 with `wb_data`=0x20, `ex_d1` stays 0x10.
- Load-use: `lw x7` in EX, then `add` with rs2=7 in ID → `id_stall`=1 for one cycle, then `ex_valid`=0 (bubble). The next cycle `ex_d2` equals the WB load data 0xCAFE.
- x0: `mem_rd`=0, `mem_reg_we`=1 and a consumer with rs1=0 → `ex_d1`=captured 0, no forward.
- Hold and flush: `ex_hold`=1 with `flush`=1 for 3 cycles → EX unchanged and `id_stall`=1. When hold drops with flush still high → `ex_valid`=0 next cycle.
- `ID_EX_FWD_EN` off: back-to-back dependent adds → 2 stall cycles; `ex_d1` equals the value captured through the WB bypass.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types for the ID/EX slice: EX control bundle and width constants.
package cpu_pkg;
  localparam int CPU_RW   = 5;
  localparam int ALU_OP_W = 4;

  typedef struct packed {
    logic                valid;
    logic                reg_we;
    logic                mem_re;
    logic                mem_we;
    logic                src1_pc;
    logic                src2_imm;
    logic [ALU_OP_W-1:0] alu_op;
  } ex_ctrl_t;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux (MEM over WB over captured value).
// Forwarding logic exists only when ID_EX_FWD_EN is defined.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int BW = 32,
  parameter int RW = CPU_RW
) (
  input  logic [RW-1:0] rs_idx_i,
  input  logic [BW-1:0] rs_val_i,
  input  logic          mem_reg_we_i,
  input  logic [RW-1:0] mem_rd_i,
  input  logic [BW-1:0] mem_result_i,
  input  logic          wb_reg_we_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [BW-1:0] wb_data_i,
  output logic [BW-1:0] fwd_val_o
);
`ifdef ID_EX_FWD_EN
  always_comb begin
    fwd_val_o = rs_val_i;
    if (rs_idx_i != '0) begin
      if (mem_reg_we_i && mem_rd_i == rs_idx_i)     fwd_val_o = mem_result_i;
      else if (wb_reg_we_i && wb_rd_i == rs_idx_i)  fwd_val_o = wb_data_i;
    end
  end
`else
  assign fwd_val_o = rs_val_i;
  logic unused_fwd;
  assign unused_fwd = ^{rs_idx_i, mem_reg_we_i, mem_rd_i, mem_result_i,
                        wb_reg_we_i, wb_rd_i, wb_data_i};
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles and ALU operand selection.
// ID_EX_FWD_EN selects MEM/WB forwarding; otherwise dependencies stall in ID.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int BW = 32,
  parameter int RW = CPU_RW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [BW-1:0]       id_pc,
  input  logic [RW-1:0]       id_rs1,
  input  logic [RW-1:0]       id_rs2,
  input  logic [RW-1:0]       id_rd,
  input  logic [BW-1:0]       id_rs1_val,
  input  logic [BW-1:0]       id_rs2_val,
  input  logic [BW-1:0]       id_imm,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_src1_pc,
  input  logic                id_src2_imm,
  input  logic                id_reg_we,
  input  logic                id_mem_re,
  input  logic                id_mem_we,
  input  logic                flush,
  input  logic                ex_hold,
  input  logic                mem_reg_we,
  input  logic [RW-1:0]       mem_rd,
  input  logic [BW-1:0]       mem_result,
  input  logic                wb_reg_we,
  input  logic [RW-1:0]       wb_rd,
  input  logic [BW-1:0]       wb_data,
  output logic                id_stall,
  output logic                ex_valid,
  output logic                ex_reg_we,
  output logic                ex_mem_re,
  output logic                ex_mem_we,
  output logic [RW-1:0]       ex_rd,
  output logic [BW-1:0]       ex_pc,
  output logic [BW-1:0]       ex_d1,
  output logic [BW-1:0]       ex_d2,
  output logic [ALU_OP_W-1:0] ex_choice,
  output logic [BW-1:0]       ex_store_data
);
  ex_ctrl_t      ctrl_q, ctrl_d;
  logic [RW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [BW-1:0] pc_q, pc_d, imm_q, imm_d, rs1v_q, rs1v_d, rs2v_q, rs2v_d;
  logic [BW-1:0] rs1_cap, rs2_cap, fwd_rs1, fwd_rs2;
  logic          load_use, hazard;

  assign load_use = ctrl_q.valid && ctrl_q.mem_re && (rd_q != '0) && id_valid &&
                    (rd_q == id_rs1 || rd_q == id_rs2);

`ifdef ID_EX_FWD_EN
  assign hazard = load_use;
`else
  // Without forwarding any producer still in EX or MEM must drain to WB first.
  logic raw1, raw2;
  assign raw1 = (id_rs1 != '0) &&
                ((ctrl_q.valid && ctrl_q.reg_we && rd_q == id_rs1) ||
                 (mem_reg_we && mem_rd == id_rs1));
  assign raw2 = (id_rs2 != '0) &&
                ((ctrl_q.valid && ctrl_q.reg_we && rd_q == id_rs2) ||
                 (mem_reg_we && mem_rd == id_rs2));
  assign hazard = load_use || (id_valid && (raw1 || raw2));
`endif

  assign id_stall = ex_hold || hazard;

  // Register file reads before it writes, so pick up the WB write on capture.
  assign rs1_cap = (wb_reg_we && wb_rd != '0 && wb_rd == id_rs1) ? wb_data : id_rs1_val;
  assign rs2_cap = (wb_reg_we && wb_rd != '0 && wb_rd == id_rs2) ? wb_data : id_rs2_val;

  always_comb begin
    ctrl_d = ctrl_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    pc_d   = pc_q;
    imm_d  = imm_q;
    rs1v_d = rs1v_q;
    rs2v_d = rs2v_q;
    if (ex_hold) begin
      // retain
    end else if (flush || hazard) begin
      ctrl_d = '0;
      rd_d   = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      pc_d   = '0;
      imm_d  = '0;
      rs1v_d = '0;
      rs2v_d = '0;
    end else begin
      ctrl_d.valid    = id_valid;
      ctrl_d.reg_we   = id_reg_we;
      ctrl_d.mem_re   = id_mem_re;
      ctrl_d.mem_we   = id_mem_we;
      ctrl_d.src1_pc  = id_src1_pc;
      ctrl_d.src2_imm = id_src2_imm;
      ctrl_d.alu_op   = id_alu_op;
      rd_d   = id_rd;
      rs1_d  = id_rs1;
      rs2_d  = id_rs2;
      pc_d   = id_pc;
      imm_d  = id_imm;
      rs1v_d = rs1_cap;
      rs2v_d = rs2_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
      rs1v_q <= '0;
      rs2v_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      pc_q   <= pc_d;
      imm_q  <= imm_d;
      rs1v_q <= rs1v_d;
      rs2v_q <= rs2v_d;
    end
  end

  fwd_mux #(.BW(BW), .RW(RW)) u_fwd_rs1 (
    .rs_idx_i(rs1_q), .rs_val_i(rs1v_q),
    .mem_reg_we_i(mem_reg_we), .mem_rd_i(mem_rd), .mem_result_i(mem_result),
    .wb_reg_we_i(wb_reg_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .fwd_val_o(fwd_rs1)
  );

  fwd_mux #(.BW(BW), .RW(RW)) u_fwd_rs2 (
    .rs_idx_i(rs2_q), .rs_val_i(rs2v_q),
    .mem_reg_we_i(mem_reg_we), .mem_rd_i(mem_rd), .mem_result_i(mem_result),
    .wb_reg_we_i(wb_reg_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .fwd_val_o(fwd_rs2)
  );

  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_we     = ctrl_q.reg_we;
  assign ex_mem_re     = ctrl_q.mem_re;
  assign ex_mem_we     = ctrl_q.mem_we;
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;
  assign ex_choice     = ctrl_q.alu_op;
  assign ex_d1         = ctrl_q.src1_pc  ? pc_q  : fwd_rs1;
  assign ex_d2         = ctrl_q.src2_imm ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, id_valid, id_src1_pc, id_src2_imm, id_reg_we, id_mem_re, id_mem_we;
  logic        flush, ex_hold, mem_reg_we, wb_reg_we;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm, mem_result, wb_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [3:0]  id_alu_op;
  logic        id_stall, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_d1, ex_d2, ex_store_data;
  logic [3:0]  ex_choice;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
    .flush(flush), .ex_hold(ex_hold),
    .mem_reg_we(mem_reg_we), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_we(wb_reg_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_reg_we(ex_reg_we),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_d1(ex_d1), .ex_d2(ex_d2), .ex_choice(ex_choice), .ex_store_data(ex_store_data)
  );

  // Model of the instruction occupying EX.
  typedef struct {
    bit        valid, reg_we, mem_re, mem_we, src1_pc, src2_imm;
    bit [3:0]  op;
    bit [4:0]  rd, rs1, rs2;
    bit [31:0] pc, imm, v1, v2;
  } ex_t;

  typedef struct {
    bit        stall, valid, reg_we, mem_re, mem_we;
    bit [4:0]  rd;
    bit [3:0]  choice;
    bit [31:0] pc, d1, d2, store;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ex_t empty_ex();
    ex_t z;
    z = '{default: '0};
    return z;
  endfunction

  // Value an instruction in EX actually sees for a source register.
  function automatic bit [31:0] operand(bit [4:0] idx, bit [31:0] held);
`ifdef ID_EX_FWD_EN
    if (idx != 0 && mem_reg_we && mem_rd == idx) return mem_result;
    if (idx != 0 && wb_reg_we && wb_rd == idx)   return wb_data;
`endif
    return held;
  endfunction

  function automatic bit writes_to(bit we, bit [4:0] dst, bit [4:0] src);
    return we && src != 0 && dst == src;
  endfunction

  function automatic bit must_wait(ex_t s);
    bit lu;
    lu = s.valid && s.mem_re && s.rd != 0 && id_valid && (s.rd == id_rs1 || s.rd == id_rs2);
`ifndef ID_EX_FWD_EN
    if (id_valid && (writes_to(s.valid && s.reg_we, s.rd, id_rs1) ||
                     writes_to(s.valid && s.reg_we, s.rd, id_rs2) ||
                     writes_to(mem_reg_we, mem_rd, id_rs1) ||
                     writes_to(mem_reg_we, mem_rd, id_rs2)))
      lu = 1'b1;
`endif
    return lu;
  endfunction

  // Monitor: compare every cycle the DUT output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_stall",      {31'd0, id_stall},  {31'd0, e.stall});
        chk("ex_valid",      {31'd0, ex_valid},  {31'd0, e.valid});
        chk("ex_reg_we",     {31'd0, ex_reg_we}, {31'd0, e.reg_we});
        chk("ex_mem_re",     {31'd0, ex_mem_re}, {31'd0, e.mem_re});
        chk("ex_mem_we",     {31'd0, ex_mem_we}, {31'd0, e.mem_we});
        chk("ex_rd",         {27'd0, ex_rd},     {27'd0, e.rd});
        chk("ex_choice",     {28'd0, ex_choice}, {28'd0, e.choice});
        chk("ex_pc",         ex_pc,              e.pc);
        chk("ex_d1",         ex_d1,              e.d1);
        chk("ex_d2",         ex_d2,              e.d2);
        chk("ex_store_data", ex_store_data,      e.store);
      end
    end
  end

  task automatic randomize_inputs(int cyc);
    rst         = (cyc < 2) || ($urandom_range(0, 99) == 0);
    id_valid    = $urandom_range(0, 9) != 0;
    id_pc       = $urandom;
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_rd       = 5'($urandom_range(0, 3));
    id_rs1_val  = $urandom;
    id_rs2_val  = $urandom;
    id_imm      = $urandom;
    id_alu_op   = 4'($urandom_range(0, 15));
    id_src1_pc  = $urandom_range(0, 3) == 0;
    id_src2_imm = $urandom_range(0, 2) == 0;
    id_reg_we   = $urandom_range(0, 4) != 0;
    id_mem_re   = $urandom_range(0, 2) == 0;
    id_mem_we   = $urandom_range(0, 6) == 0;
    flush       = $urandom_range(0, 11) == 0;
    ex_hold     = $urandom_range(0, 7) == 0;
    mem_reg_we  = $urandom_range(0, 4) < 3;
    mem_rd      = 5'($urandom_range(0, 3));
    mem_result  = $urandom;
    wb_reg_we   = $urandom_range(0, 4) < 3;
    wb_rd       = 5'($urandom_range(0, 3));
    wb_data     = $urandom;
  endtask

  initial begin
    ex_t  st, nxt;
    exp_t e;
    bit   wait_id;
    randomize_inputs(0);
    nxt = empty_ex();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      st = nxt;
      #1;
      randomize_inputs(cyc);

      wait_id  = must_wait(st);
      e.stall  = ex_hold || wait_id;
      e.valid  = st.valid;
      e.reg_we = st.reg_we;
      e.mem_re = st.mem_re;
      e.mem_we = st.mem_we;
      e.rd     = st.rd;
      e.choice = st.op;
      e.pc     = st.pc;
      e.d1     = st.src1_pc  ? st.pc  : operand(st.rs1, st.v1);
      e.d2     = st.src2_imm ? st.imm : operand(st.rs2, st.v2);
      e.store  = operand(st.rs2, st.v2);
      q.push_back(e);

      if (rst) nxt = empty_ex();
      else if (ex_hold) nxt = st;
      else if (flush || wait_id) nxt = empty_ex();
      else begin
        nxt.valid    = id_valid;
        nxt.reg_we   = id_reg_we;
        nxt.mem_re   = id_mem_re;
        nxt.mem_we   = id_mem_we;
        nxt.src1_pc  = id_src1_pc;
        nxt.src2_imm = id_src2_imm;
        nxt.op       = id_alu_op;
        nxt.rd       = id_rd;
        nxt.rs1      = id_rs1;
        nxt.rs2      = id_rs2;
        nxt.pc       = id_pc;
        nxt.imm      = id_imm;
        nxt.v1       = writes_to(wb_reg_we, wb_rd, id_rs1) ? wb_data : id_rs1_val;
        nxt.v2       = writes_to(wb_reg_we, wb_rd, id_rs2) ? wb_data : id_rs2_val;
      end
    end
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
